pma_region_checker: RTL and testbench
=====================================

Name: pma_region_checker

Overview:
- Pipelined, runtime-programmable PMA lookup unit. It replaces the static per-attribute region checks of the core configuration with a single table of up to NrRules regions.
- Each rule carries an attribute mask. A lookup returns the OR-reduced attributes plus the lowest-index hit.
- Sits between address generation (fetch or LSU) and the MMU/PMP result merge. A CSR-side write port reprograms rules, and individual rules can be locked.

Parameters:
- NrRules, 16, number of table entries (1..16, the NrMaxRules ceiling).
- AddrWidth, 64, lookup address and base/length width.
- NrAttr, 3, attribute bits per rule: bit0 non-idempotent, bit1 execute, bit2 cacheable.
- RstBase, '0, logic [NrRules-1:0][AddrWidth-1:0], reset base values.
- RstLen, '0, same shape, reset length values.
- RstAttr, '0, logic [NrRules-1:0][NrAttr-1:0], reset attribute masks.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  lookup request valid.
- req_ready_o  out  1  lookup request accepted this cycle.
- req_addr_i  in  AddrWidth  address to classify.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result consumed.
- rsp_hit_o  out  1  at least one rule matched.
- rsp_idx_o  out  $clog2(NrRules)  lowest matching rule index (0 if no hit).
- rsp_attr_o  out  NrAttr  OR of the attribute masks of all matching rules, with the execute default applied.
- cfg_we_i  in  1  rule write strobe.
- cfg_idx_i  in  $clog2(NrRules)  rule to write.
- cfg_base_i  in  AddrWidth  new base.
- cfg_len_i  in  AddrWidth  new length.
- cfg_attr_i  in  NrAttr  new attribute mask.
- cfg_lock_i  in  1  lock the rule together with this write.
- cfg_err_o  out  1  one-cycle pulse when a write targets a locked rule or an index >= NrRules.

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - Table loads RstBase, RstLen and RstAttr; all lock bits clear.
  - Both pipeline valids clear, so rsp_valid_o=0 and cfg_err_o=0.
  - Any in-flight lookups are dropped without a response.
  - req_ready_o=1 from the first cycle after reset deasserts.
- Match rule, per entry:
  - hit = (addr >= base) && ({1'b0,addr} < {1'b0,base} + {1'b0,len}), evaluated at AddrWidth+1 bits so there is no overflow.
  - len==0 never hits.
  - base+len reaching 2^AddrWidth covers up to the all-ones address.
- Pipeline:
  - Stage S1 registers the address and the per-rule hit vector, computed against table contents at acceptance.
  - Stage S2 registers the reduced result.
  - Latency: an accepted request's response is visible 2 cycles after acceptance. Throughput is 1 per cycle.
- Handshake:
  - Request accepted when req_valid_i && req_ready_o.
  - req_ready_o = !s1_valid || !s2_valid || rsp_ready_i (i.e. S1 can advance).
  - Each stage advances only when the next stage is empty or draining.
  - Outputs hold stable while rsp_valid_o && !rsp_ready_i.
  - No combinational path from req_valid_i to req_ready_o.
- Reduction in S2:
  - rsp_hit_o = |hits; rsp_idx_o = priority encoder, lowest index wins.
  - rsp_attr_o = OR of attr[k] over all hit k.
  - Execute default: if no table entry has attr bit1 set, rsp_attr_o[1]=1 regardless of hits.
- Write port:
  - A write updates the entry at the clock edge if cfg_idx_i < NrRules and the entry is unlocked.
  - cfg_lock_i=1 sets that entry's lock, which clears only on reset.
  - A rejected write leaves the entry unchanged and sets cfg_err_o=1 for exactly the next cycle.
  - Writes are never back-pressured.
- Simultaneous write and lookup to the same rule in one cycle: the request accepted that cycle uses the old entry. Requests accepted from the next cycle onward use the new entry. In-flight S1/S2 results are never recomputed.

Decomposition:
- Shared package (config_pkg): pma_attr_e bit positions (PmaNonIdem=0, PmaExec=1, PmaCache=2) and pma_rule_t struct {base, len, attr, lock}. NrMaxRules already lives there.
- Sub-module pma_range_match: purely combinational single-rule comparator (addr, base, len -> hit), instantiated NrRules times. It implements the overflow-safe compare.

Test Plan:
1. Reset with RstBase[0]=0x8000_0000, RstLen[0]=0x1000, RstAttr[0]=3'b100; lookup 0x8000_0FFF -> 2 cycles later hit=1, idx=0, attr=3'b110 (execute default applies); lookup 0x8000_1000 -> hit=0, attr=3'b010.
2. Rule 2 and rule 5 both cover 0x1000 with attrs 3'b001 and 3'b100 -> idx=2, attr=3'b101 if some rule has the exec bit set, otherwise 3'b111.
3. Back-to-back 8 requests with rsp_ready_i low for 3 cycles mid-stream -> req_ready_o drops once both stages are full; responses arrive in order with none lost or duplicated; outputs stable while stalled.
4. Write rule 1 (base 0x2000, len 0x100, lock=1) in the same cycle a lookup of 0x2000 is accepted -> that lookup misses; the next lookup hits idx=1; a second write to rule 1 -> cfg_err_o pulses once and the entry is unchanged.
5. Rule with base=0xFFFF_FFFF_FFFF_FF00, len=0x100 -> address 0xFFFF_FFFF_FFFF_FFFF hits; len=0 on any rule never hits.
6. Reset asserted with both stages full -> rsp_valid_o=0 the cycle after; no stale response; locks cleared so a write to rule 1 succeeds.

Source files
------------

// File: rtl/pma_region_checker_pkg.sv
// Shared PMA definitions: attribute bit positions, rule record and table ceiling.
package pma_region_checker_pkg;

  localparam int unsigned NrMaxRules = 16;
  localparam int unsigned PmaAddrW   = 64;
  localparam int unsigned PmaNrAttr  = 3;

  typedef enum int unsigned {
    PmaNonIdem = 0,
    PmaExec    = 1,
    PmaCache   = 2
  } pma_attr_e;

  typedef struct packed {
    logic [PmaAddrW-1:0]  base;
    logic [PmaAddrW-1:0]  len;
    logic [PmaNrAttr-1:0] attr;
    logic                 lock;
  } pma_rule_t;

endpackage

// File: rtl/pma_region_checker_match.sv
// Single-rule range comparator; the end bound is formed one bit wider so
// regions reaching the top of the address space cannot wrap.
module pma_range_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] len_i,
  output logic                 hit_o
);

  logic [AddrWidth:0] end_w;

  assign end_w = {1'b0, base_i} + {1'b0, len_i};
  // len==0 gives end==base, so the two bounds exclude every address.
  assign hit_o = (addr_i >= base_i) && ({1'b0, addr_i} < end_w);

endmodule

// File: rtl/pma_region_checker.sv
// Two-stage PMA lookup: S1 captures per-rule hits against the table at
// acceptance, S2 holds the reduced hit/index/attribute result.
module pma_region_checker
  import pma_region_checker_pkg::*;
#(
  parameter int unsigned NrRules   = 16,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned NrAttr    = 3,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase = '0,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLen  = '0,
  parameter logic [NrRules-1:0][NrAttr-1:0]    RstAttr = '0,
  localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxW-1:0]      rsp_idx_o,
  output logic [NrAttr-1:0]    rsp_attr_o,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [NrAttr-1:0]    cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o
);

  localparam int unsigned ExecBit = int'(PmaExec);

  logic [NrRules-1:0][AddrWidth-1:0] base_q, len_q;
  logic [NrRules-1:0][NrAttr-1:0]    attr_q;
  logic [NrRules-1:0]                lock_q;
  logic                              err_q;

  logic [NrRules-1:0]             hit_d;
  logic [NrRules-1:0][NrAttr-1:0] hattr_d;
  logic                           xdef_d;

  logic                           s1_vld_q, s1_xdef_q;
  logic [NrRules-1:0]             s1_hit_q;
  logic [NrRules-1:0][NrAttr-1:0] s1_hattr_q;

  logic              s2_vld_q, s2_hit_q;
  logic [IdxW-1:0]   s2_idx_q, idx_d;
  logic [NrAttr-1:0] s2_attr_q, attr_d;

  logic s2_adv, accept, cfg_inrange, cfg_wr;

  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    pma_range_match #(.AddrWidth(AddrWidth)) u_match (
      .addr_i (req_addr_i),
      .base_i (base_q[g]),
      .len_i  (len_q[g]),
      .hit_o  (hit_d[g])
    );
    assign hattr_d[g] = hit_d[g] ? attr_q[g] : '0;
  end

  // Execute default is judged on the table as seen at acceptance.
  always_comb begin
    xdef_d = 1'b1;
    for (int k = 0; k < int'(NrRules); k++)
      if (attr_q[k][ExecBit]) xdef_d = 1'b0;
  end

  always_comb begin
    idx_d  = '0;
    attr_d = '0;
    for (int k = int'(NrRules) - 1; k >= 0; k--)
      if (s1_hit_q[k]) idx_d = IdxW'(k);
    for (int k = 0; k < int'(NrRules); k++)
      attr_d = attr_d | s1_hattr_q[k];
    if (s1_xdef_q) attr_d[ExecBit] = 1'b1;
  end

  assign s2_adv      = !s2_vld_q || rsp_ready_i;
  assign req_ready_o = !s1_vld_q || s2_adv;
  assign accept      = req_valid_i && req_ready_o;

  assign cfg_inrange = 32'(cfg_idx_i) < NrRules;
  assign cfg_wr      = cfg_we_i && cfg_inrange && !lock_q[cfg_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q   <= 1'b0;
      s1_xdef_q  <= 1'b0;
      s1_hit_q   <= '0;
      s1_hattr_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_attr_q  <= '0;
    end else begin
      if (req_ready_o) s1_vld_q <= req_valid_i;
      if (accept) begin
        s1_hit_q   <= hit_d;
        s1_hattr_q <= hattr_d;
        s1_xdef_q  <= xdef_d;
      end
      if (s2_adv) s2_vld_q <= s1_vld_q;
      if (s2_adv && s1_vld_q) begin
        s2_hit_q  <= |s1_hit_q;
        s2_idx_q  <= idx_d;
        s2_attr_q <= attr_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= RstBase;
      len_q  <= RstLen;
      attr_q <= RstAttr;
      lock_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= cfg_we_i && !cfg_wr;
      if (cfg_wr) begin
        base_q[cfg_idx_i] <= cfg_base_i;
        len_q[cfg_idx_i]  <= cfg_len_i;
        attr_q[cfg_idx_i] <= cfg_attr_i;
        lock_q[cfg_idx_i] <= cfg_lock_i;
      end
    end
  end

  assign rsp_valid_o = s2_vld_q;
  assign rsp_hit_o   = s2_hit_q;
  assign rsp_idx_o   = s2_idx_q;
  assign rsp_attr_o  = s2_attr_q;
  assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_pma_region_checker.sv
// Randomized bench for pma_region_checker: a table-level model predicts every
// response, ready, error pulse and stall hold, monitored on the falling edge.
module tb_pma_region_checker;
  import pma_region_checker_pkg::*;

  localparam int NR = 16;
  localparam int AW = 64;
  localparam int NA = 3;
  localparam logic [NR-1:0][AW-1:0] RST_BASE = {{(NR-1){64'h0}}, 64'h8000_0000};
  localparam logic [NR-1:0][AW-1:0] RST_LEN  = {{(NR-1){64'h0}}, 64'h0000_1000};
  localparam logic [NR-1:0][NA-1:0] RST_ATTR = {{(NR-1){3'b000}}, 3'b100};

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0, req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic          rsp_valid_o, rsp_ready_i = 1'b1, rsp_hit_o;
  logic [3:0]    rsp_idx_o;
  logic [NA-1:0] rsp_attr_o;
  logic          cfg_we_i = 1'b0, cfg_lock_i = 1'b0, cfg_err_o;
  logic [3:0]    cfg_idx_i = '0;
  logic [AW-1:0] cfg_base_i = '0, cfg_len_i = '0;
  logic [NA-1:0] cfg_attr_i = '0;

  pma_region_checker #(
    .NrRules(NR), .AddrWidth(AW), .NrAttr(NA),
    .RstBase(RST_BASE), .RstLen(RST_LEN), .RstAttr(RST_ATTR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
    .rsp_idx_o(rsp_idx_o), .rsp_attr_o(rsp_attr_o),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_base_i(cfg_base_i),
    .cfg_len_i(cfg_len_i), .cfg_attr_i(cfg_attr_i), .cfg_lock_i(cfg_lock_i),
    .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         hit;
    logic [3:0] idx;
    logic [2:0] attr;
    int         acc;
  } exp_t;

  pma_rule_t tbl [NR];
  exp_t      q[$];
  int        cyc = 0, last_pop = 0;
  bit        exp_err = 0, stall_prev = 0;
  logic      held_hit;
  logic [3:0] held_idx;
  logic [2:0] held_attr;

  function automatic void model_reset();
    for (int k = 0; k < NR; k++) begin
      tbl[k].base = RST_BASE[k];
      tbl[k].len  = RST_LEN[k];
      tbl[k].attr = RST_ATTR[k];
      tbl[k].lock = 1'b0;
    end
  endfunction

  function automatic exp_t model_lookup(logic [63:0] a);
    exp_t r;
    bit   xany = 0;
    r.hit = 0; r.idx = '0; r.attr = '0; r.acc = 0;
    for (int k = 0; k < NR; k++) begin
      if (tbl[k].attr[1]) xany = 1;
      if (tbl[k].len != 0 && a >= tbl[k].base && (a - tbl[k].base) < tbl[k].len) begin
        if (!r.hit) begin r.hit = 1; r.idx = 4'(k); end
        r.attr |= tbl[k].attr;
      end
    end
    if (!xany) r.attr[1] = 1'b1;
    return r;
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    bit   exp_v;
    cyc++;
    if (rst_i) begin
      q.delete();
      model_reset();
      exp_err    = 0;
      stall_prev = 0;
      last_pop   = cyc;
    end else begin
      chk("req_ready", req_ready_o, (q.size() < 2) || rsp_ready_i);
      exp_v = q.size() > 0 && cyc >= q[0].acc + 2 && cyc > last_pop;
      chk("rsp_valid", rsp_valid_o, exp_v);
      if (rsp_valid_o && exp_v) begin
        chk("rsp_hit",  rsp_hit_o,  q[0].hit);
        chk("rsp_idx",  rsp_idx_o,  q[0].idx);
        chk("rsp_attr", rsp_attr_o, q[0].attr);
      end
      if (stall_prev) begin
        chk("hold_valid", rsp_valid_o, 1'b1);
        chk("hold_rsp", {rsp_hit_o, rsp_idx_o, rsp_attr_o}, {held_hit, held_idx, held_attr});
      end
      chk("cfg_err", cfg_err_o, exp_err);
      if (rsp_valid_o && rsp_ready_i && q.size() > 0) begin
        void'(q.pop_front());
        last_pop = cyc;
      end
      stall_prev = rsp_valid_o && !rsp_ready_i;
      held_hit = rsp_hit_o; held_idx = rsp_idx_o; held_attr = rsp_attr_o;
      if (req_valid_i && req_ready_o) begin
        e = model_lookup(req_addr_i);
        e.acc = cyc;
        q.push_back(e);
      end
      exp_err = 0;
      if (cfg_we_i) begin
        if (tbl[cfg_idx_i].lock) exp_err = 1;
        else begin
          tbl[cfg_idx_i].base = cfg_base_i;
          tbl[cfg_idx_i].len  = cfg_len_i;
          tbl[cfg_idx_i].attr = cfg_attr_i;
          tbl[cfg_idx_i].lock = cfg_lock_i;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic wr(input int idx, input logic [63:0] b, input logic [63:0] l,
                    input logic [2:0] a, input bit lk);
    cfg_we_i = 1; cfg_idx_i = 4'(idx); cfg_base_i = b; cfg_len_i = l;
    cfg_attr_i = a; cfg_lock_i = lk;
    step();
    cfg_we_i = 0; cfg_lock_i = 0;
  endtask

  task automatic look(input logic [63:0] a);
    req_valid_i = 1; req_addr_i = a;
    step();
    req_valid_i = 0;
  endtask

  task automatic burst(input int n, input logic [63:0] a0, input int stall_from, input int stall_to);
    int sent = 0;
    for (int t = 0; t < 40 && sent < n; t++) begin
      req_valid_i = 1; req_addr_i = a0 + 64'(sent);
      rsp_ready_i = !(t >= stall_from && t < stall_to);
      @(negedge clk_i);
      if (req_ready_o) sent++;
      step();
    end
    req_valid_i = 0;
    chk("burst_sent", sent, n);
  endtask

  initial begin
    repeat (3) step();
    rst_i = 0;
    // reset-table hit at the top byte and miss one past the end
    look(64'h8000_0FFF);
    look(64'h8000_1000);
    repeat (3) step();
    // overlapping rules, with and without an exec bit anywhere
    wr(2, 64'h1000, 64'h10, 3'b001, 0);
    wr(5, 64'h0800, 64'h1000, 3'b100, 0);
    look(64'h1000);
    wr(3, 64'h0, 64'h0, 3'b010, 0);
    look(64'h1000);
    repeat (3) step();
    // back-to-back with a 3-cycle stall mid-stream
    burst(8, 64'h1000, 3, 6);
    rsp_ready_i = 1;
    repeat (4) step();
    // write + lookup same cycle, then locked rewrite
    cfg_we_i = 1; cfg_idx_i = 4'd1; cfg_base_i = 64'h2000; cfg_len_i = 64'h100;
    cfg_attr_i = 3'b000; cfg_lock_i = 1;
    req_valid_i = 1; req_addr_i = 64'h2000;
    step();
    cfg_we_i = 0; cfg_lock_i = 0; req_valid_i = 0;
    look(64'h2000);
    wr(1, 64'h3000, 64'h10, 3'b001, 0);
    look(64'h2000);
    look(64'h3000);
    repeat (3) step();
    // top-of-space rule and zero-length rule
    wr(6, 64'hFFFF_FFFF_FFFF_FF00, 64'h100, 3'b001, 0);
    look(64'hFFFF_FFFF_FFFF_FFFF);
    look(64'hFFFF_FFFF_FFFF_FEFF);
    wr(7, 64'h5000, 64'h0, 3'b010, 0);
    look(64'h5000);
    repeat (3) step();
    // reset with both stages full, then lock is gone
    burst(2, 64'h8000_0000, 0, 40);
    rst_i = 1;
    step();
    rst_i = 0; rsp_ready_i = 1;
    step();
    wr(1, 64'h2000, 64'h40, 3'b010, 0);
    look(64'h2010);
    repeat (3) step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] bases [4] = '{64'h1000, 64'h2000, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF00};
      logic [63:0] lens  [4] = '{64'h0, 64'h1, 64'h100, 64'h1000};
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_addr_i  = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)}
                    : bases[$urandom_range(0, 3)] + 64'($urandom_range(0, 300)) - 64'd20;
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      cfg_we_i    = ($urandom_range(0, 9) == 0);
      cfg_idx_i   = 4'($urandom_range(0, NR - 1));
      cfg_base_i  = bases[$urandom_range(0, 3)];
      cfg_len_i   = lens[$urandom_range(0, 3)];
      cfg_attr_i  = 3'($urandom_range(0, 7));
      cfg_lock_i  = ($urandom_range(0, 15) == 0);
      if (i == 1500) rst_i = 1;
      step();
      rst_i = 0;
    end
    req_valid_i = 0; cfg_we_i = 0; rsp_ready_i = 1;
    for (int t = 0; t < 20 && q.size() != 0; t++) step();
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
